mem_access_unit: RTL

//   MEM-stage data-memory sequencer, directly downstream of the EX-stage control register.

---
 rtl/mem_access_unit_pkg.sv | 51 +++++
 rtl/mem_access_unit_load_extend.sv | 27 ++
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM-stage data-memory sequencer: load kinds, FSM states
// and byte-mask constants.
package mem_access_unit_pkg;

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LW  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [2:0] {
    LK_BYTE_S = 3'd0,
    LK_HALF_S = 3'd1,
    LK_WORD   = 3'd2,
    LK_BYTE_U = 3'd3,
    LK_HALF_U = 3'd4
  } load_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Unknown load_type codes fall back to a full word load.
  function automatic load_kind_e decode_load_type(input logic [2:0] lt);
    case (lt)
      LT_LB:   decode_load_type = LK_BYTE_S;
      LT_LH:   decode_load_type = LK_HALF_S;
      LT_LW:   decode_load_type = LK_WORD;
      LT_LBU:  decode_load_type = LK_BYTE_U;
      LT_LHU:  decode_load_type = LK_HALF_U;
      default: decode_load_type = LK_WORD;
    endcase
  endfunction

  function automatic logic [3:0] load_mask(input load_kind_e kind);
    case (kind)
      LK_BYTE_S, LK_BYTE_U: load_mask = MASK_BYTE;
      LK_HALF_S, LK_HALF_U: load_mask = MASK_HALF;
      LK_WORD:              load_mask = MASK_WORD;
      default:              load_mask = MASK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load lane select plus sign/zero extension; shared with the
// forwarding path so both see identical load results.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  sel,
  input  load_kind_e  kind,
  output logic [31:0] data
);

  logic [31:0] shifted_s;

  // Shift the addressed lane down to bit 0, then extend per load kind.
  always_comb begin
    shifted_s = rdata >> {sel, 3'b000};
    case (kind)
      LK_BYTE_S: data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      LK_HALF_S: data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      LK_BYTE_U: data = {24'h000000, shifted_s[7:0]};
      LK_HALF_U: data = {16'h0000, shifted_s[15:0]};
      LK_WORD:   data = shifted_s;
      default:   data = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer: runs one req/gnt/rvalid transaction per
// access, stalls the pipeline meanwhile and returns extended load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cache_read_en,
  input  logic [3:0]    cache_write_en,
  input  logic [2:0]    load_type,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   store_data,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i,
  output logic [31:0]   load_data_o,
  output logic          load_valid_o,
  output logic          stall_o,
  output logic          bus_err_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_r, state_s;
  logic [CW-1:0] cnt_r;
  logic          we_r;
  logic [3:0]    be_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   wdata_r;
  load_kind_e    kind_r;
  logic [31:0]   load_data_r;
  logic          load_valid_r;
  logic          bus_err_r;

  logic          access_s;
  logic          stall_s;
  load_kind_e    kind_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic [31:0]   ext_s;
  logic          timeout_s;

  assign access_s  = cache_read_en | (|cache_write_en);
  assign kind_s    = decode_load_type(load_type);
  assign timeout_s = (cnt_r == CNT_LAST) & ~mem_rvalid_i;

  // Request bundle as it would be latched this cycle; a set read enable wins over stores.
  always_comb begin
    if (cache_read_en) begin
      be_s = load_mask(kind_s) << addr[1:0];
    end else begin
      be_s = cache_write_en << addr[1:0];
    end
    wdata_s = store_data << {addr[1:0], 3'b000};
  end

  // Next-state and stall decode.
  always_comb begin
    state_s = state_r;
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s) begin
          state_s = ST_REQ;
          stall_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_s = 1'b1;
        if (mem_gnt_i) begin
          state_s = we_r ? ST_DONE : ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        stall_s = 1'b1;
        if (mem_rvalid_i || timeout_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Timeout counter: counts WAIT cycles, cleared everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt_r <= '0;
    else if (state_r == ST_WAIT) cnt_r <= cnt_r + 1'b1;
    else                        cnt_r <= '0;
  end

  // Registered request bundle, frozen from IDLE until the next access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      be_r    <= 4'b0000;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      kind_r  <= LK_WORD;
    end else if (state_r == ST_IDLE && access_s) begin
      we_r    <= ~cache_read_en;
      be_r    <= be_s;
      addr_r  <= addr;
      wdata_r <= wdata_s;
      kind_r  <= kind_s;
    end
  end

  mem_access_unit_load_extend u_load_extend (
    .rdata (mem_rdata_i),
    .sel   (addr_r[1:0]),
    .kind  (kind_r),
    .data  (ext_s)
  );

  // Load result, one-cycle valid pulse in DONE, and sticky bus error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data_r  <= 32'h0000_0000;
      load_valid_r <= 1'b0;
      bus_err_r    <= 1'b0;
    end else if (state_r == ST_WAIT && mem_rvalid_i) begin
      load_data_r  <= ext_s;
      load_valid_r <= 1'b1;
    end else if (state_r == ST_WAIT && timeout_s) begin
      load_data_r  <= 32'h0000_0000;
      load_valid_r <= 1'b1;
      bus_err_r    <= 1'b1;
    end else begin
      load_valid_r <= 1'b0;
    end
  end

  assign mem_req_o    = (state_r == ST_REQ);
  assign mem_we_o     = we_r;
  assign mem_be_o     = be_r;
  assign mem_addr_o   = {addr_r[AW-1:2], 2'b00};
  assign mem_wdata_o  = wdata_r;
  assign load_data_o  = load_data_r;
  assign load_valid_o = load_valid_r;
  assign stall_o      = stall_s;
  assign bus_err_o    = bus_err_r;

endmodule
